// File: rtl/park_lane_counter.sv
// Multi-lane parking occupancy counter: two-beam direction sensing per lane,
// synchronized and debounced beams, per-lane sequence FSMs, saturated count.
module park_lane_counter #(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 8,
  parameter int CAPACITY  = 200,
  parameter int TICK_DIV  = 262144,
  parameter int DEB_LEN   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_LANES-1:0] SensA,
  input  logic [NUM_LANES-1:0] SensB,
  output logic [CNT_W-1:0]     CarCount,
  output logic                 Full,
  output logic                 Empty,
  output logic [NUM_LANES-1:0] InPulse,
  output logic [NUM_LANES-1:0] OutPulse,
  output logic [NUM_LANES-1:0] LaneBusy,
  output logic                 ClampErr
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = CNT_W + 4;
  localparam logic [PW-1:0]           PSC_MAX = PW'(TICK_DIV - 1);
  localparam logic signed [SUM_W-1:0] CAP_S   = SUM_W'(CAPACITY);
  localparam logic [CNT_W-1:0]        CAP_C   = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} lane_st_t;

  logic [PW-1:0]          psc;
  logic                   vld_p1;
  logic [NUM_LANES-1:0]   sa_p0, sa_p1, sb_p0, sb_p1;
  logic [DEB_LEN-1:0]     hista_p2 [NUM_LANES];
  logic [DEB_LEN-1:0]     histb_p2 [NUM_LANES];
  logic [NUM_LANES-1:0]   deba_p3, debb_p3;
  lane_st_t               st_p4 [NUM_LANES];
  lane_st_t               st_d  [NUM_LANES];
  logic [NUM_LANES-1:0]   in_d, out_d, inp_p4, outp_p4, busy_p4;
  logic signed [SUM_W-1:0] sum_d;
  logic                   clamp_d;
  logic [CNT_W-1:0]       cnt_p5;
  logic                   clamp_p5;

  function automatic logic signed [SUM_W-1:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic signed [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++)
      n = n + $signed({{(SUM_W-1){1'b0}}, v[i]});
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v[SUM_W-1])    r = '0;
    else if (v > CAP_S) r = CAP_C;
    else               r = v[CNT_W-1:0];
    return r;
  endfunction

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] || (v > CAP_S);
  endfunction

  // Debounce sample strobe; constant 1 when TICK_DIV == 1
  assign vld_p1 = (psc == PSC_MAX);

  // p0/p1: two-flop synchronizers; p2: sample history; p3: debounced beams
  always_ff @(posedge Clk) begin
    if (Reset) begin
      psc     <= '0;
      sa_p0   <= '0;
      sa_p1   <= '0;
      sb_p0   <= '0;
      sb_p1   <= '0;
      deba_p3 <= '0;
      debb_p3 <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        hista_p2[i] <= '0;
        histb_p2[i] <= '0;
      end
    end else begin
      psc   <= vld_p1 ? '0 : psc + 1'b1;
      sa_p0 <= SensA;
      sa_p1 <= sa_p0;
      sb_p0 <= SensB;
      sb_p1 <= sb_p0;
      if (vld_p1) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          hista_p2[i] <= {hista_p2[i][DEB_LEN-2:0], sa_p1[i]};
          histb_p2[i] <= {histb_p2[i][DEB_LEN-2:0], sb_p1[i]};
          if (&hista_p2[i])       deba_p3[i] <= 1'b1;
          else if (~|hista_p2[i]) deba_p3[i] <= 1'b0;
          if (&histb_p2[i])       debb_p3[i] <= 1'b1;
          else if (~|histb_p2[i]) debb_p3[i] <= 1'b0;
        end
      end
    end
  end

  // p4: lane direction FSMs; an event fires only on the final return to IDLE
  always_comb begin
    logic [1:0] ab;
    ab    = 2'b00;
    in_d  = '0;
    out_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      st_d[i] = st_p4[i];
      ab      = {deba_p3[i], debb_p3[i]};
      case (st_p4[i])
        IDLE: if (ab == 2'b10) st_d[i] = IN1;
              else if (ab == 2'b01) st_d[i] = OUT1;
        IN1:  if (ab == 2'b11) st_d[i] = IN2;
              else if (ab == 2'b00) st_d[i] = IDLE;
        IN2:  if (ab == 2'b01) st_d[i] = IN3;
              else if (ab == 2'b10) st_d[i] = IN1;
        IN3:  if (ab == 2'b00) begin
                st_d[i] = IDLE;
                in_d[i] = 1'b1;
              end else if (ab == 2'b11) st_d[i] = IN2;
        OUT1: if (ab == 2'b11) st_d[i] = OUT2;
              else if (ab == 2'b00) st_d[i] = IDLE;
        OUT2: if (ab == 2'b10) st_d[i] = OUT3;
              else if (ab == 2'b01) st_d[i] = OUT1;
        OUT3: if (ab == 2'b00) begin
                st_d[i]  = IDLE;
                out_d[i] = 1'b1;
              end else if (ab == 2'b11) st_d[i] = OUT2;
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // p5: entries and exits from all lanes net out before the clamp
  assign sum_d   = $signed({4'b0000, cnt_p5}) + popcnt(inp_p4) - popcnt(outp_p4);
  assign clamp_d = sat_hit(sum_d);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_LANES; i++) st_p4[i] <= IDLE;
      inp_p4   <= '0;
      outp_p4  <= '0;
      busy_p4  <= '0;
      cnt_p5   <= '0;
      clamp_p5 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        st_p4[i]   <= st_d[i];
        busy_p4[i] <= (st_d[i] != IDLE);
      end
      inp_p4   <= in_d;
      outp_p4  <= out_d;
      cnt_p5   <= sat_count(sum_d);
      clamp_p5 <= clamp_d;
    end
  end

  assign CarCount = cnt_p5;
  assign Full     = (cnt_p5 == CAP_C);
  assign Empty    = (cnt_p5 == '0);
  assign InPulse  = inp_p4;
  assign OutPulse = outp_p4;
  assign LaneBusy = busy_p4;
  assign ClampErr = clamp_p5;

endmodule

// File: tb/tb_park_lane_counter.sv
// Bench for park_lane_counter: two instances (capacity 200 and 3) share the
// same sensor stimulus; expected events are queued and checked as they appear.
module tb_park_lane_counter;

  localparam int CAP_A = 200;
  localparam int CAP_B = 3;

  typedef struct {
    logic [1:0] in_l;
    logic [1:0] out_l;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       clamp_a;
    logic       clamp_b;
  } txn_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] SensA = '0;
  logic [1:0] SensB = '0;

  logic [7:0] cnt_a, cnt_b;
  logic       full_a, full_b, empty_a, empty_b, clamp_a, clamp_b;
  logic [1:0] in_a, in_b, out_a, out_b, busy_a, busy_b;

  int   n_chk = 0;
  int   n_fail = 0;
  txn_t exp_q[$];
  txn_t cur;
  txn_t tbl [10];
  logic chk_pend = 1'b0;
  logic [7:0] last_a = '0;
  logic [7:0] last_b = '0;
  logic busy_seen;

  always #5 Clk = ~Clk;

  park_lane_counter #(.NUM_LANES(2), .CNT_W(8), .CAPACITY(CAP_A), .TICK_DIV(1), .DEB_LEN(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .SensA(SensA), .SensB(SensB),
    .CarCount(cnt_a), .Full(full_a), .Empty(empty_a), .InPulse(in_a),
    .OutPulse(out_a), .LaneBusy(busy_a), .ClampErr(clamp_a));

  park_lane_counter #(.NUM_LANES(2), .CNT_W(8), .CAPACITY(CAP_B), .TICK_DIV(1), .DEB_LEN(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .SensA(SensA), .SensB(SensB),
    .CarCount(cnt_b), .Full(full_b), .Empty(empty_b), .InPulse(in_b),
    .OutPulse(out_b), .LaneBusy(busy_b), .ClampErr(clamp_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Scoreboard: every pulse must match the queued event; the count and clamp
  // are checked one cycle later, and must stay put on all other cycles.
  always @(posedge Clk) begin
    #1;
    if (Reset) begin
      chk_pend = 1'b0;
    end else begin
      if (chk_pend) begin
        check("cnt_a", cnt_a, cur.cnt_a);
        check("cnt_b", cnt_b, cur.cnt_b);
        check("clamp_a", clamp_a, cur.clamp_a);
        check("clamp_b", clamp_b, cur.clamp_b);
        check("full_a", full_a, cur.cnt_a == 8'(CAP_A));
        check("full_b", full_b, cur.cnt_b == 8'(CAP_B));
        check("empty_a", empty_a, cur.cnt_a == 8'd0);
        check("empty_b", empty_b, cur.cnt_b == 8'd0);
        last_a   = cur.cnt_a;
        last_b   = cur.cnt_b;
        chk_pend = 1'b0;
      end else begin
        check("hold_cnt_a", cnt_a, last_a);
        check("hold_cnt_b", cnt_b, last_b);
        check("idle_clamp_a", clamp_a, 0);
        check("idle_clamp_b", clamp_b, 0);
      end
      if (|{in_a, out_a, in_b, out_b}) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {in_a, out_a, in_b, out_b}, 0);
        end else begin
          cur = exp_q.pop_front();
          check("in_a", in_a, cur.in_l);
          check("out_a", out_a, cur.out_l);
          check("in_b", in_b, cur.in_l);
          check("out_b", out_b, cur.out_l);
          chk_pend = 1'b1;
        end
      end
    end
  end

  // Entry lanes walk A, AB, B, none; exit lanes walk B, AB, A, none, in lockstep
  task automatic run_txn(input txn_t t);
    logic done;
    exp_q.push_back(t);
    SensA = t.in_l;           SensB = t.out_l;           hold(10);
    SensA = t.in_l | t.out_l; SensB = t.in_l | t.out_l; hold(10);
    SensA = t.out_l;          SensB = t.in_l;            hold(10);
    SensA = '0;               SensB = '0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      hold(1);
      done = (exp_q.size() == 0) && !chk_pend;
    end
    check("txn_done", done, 1);
  endtask

  initial begin
    tbl[0] = '{2'b01, 2'b00, 8'd1, 8'd1, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 2'b00, 8'd2, 8'd2, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 2'b00, 8'd3, 8'd3, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 2'b00, 8'd4, 8'd3, 1'b0, 1'b1};
    tbl[4] = '{2'b01, 2'b00, 8'd5, 8'd3, 1'b0, 1'b1};
    tbl[5] = '{2'b01, 2'b10, 8'd5, 8'd3, 1'b0, 1'b0};
    tbl[6] = '{2'b00, 2'b10, 8'd4, 8'd2, 1'b0, 1'b0};
    tbl[7] = '{2'b00, 2'b01, 8'd3, 8'd1, 1'b0, 1'b0};
    tbl[8] = '{2'b00, 2'b10, 8'd2, 8'd0, 1'b0, 1'b0};
    tbl[9] = '{2'b00, 2'b10, 8'd1, 8'd0, 1'b0, 1'b1};

    hold(3);
    Reset = 1'b0;
    hold(100);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_b", cnt_b, 0);
    check("rst_empty_a", empty_a, 1);
    check("rst_full_a", full_a, 0);
    check("rst_empty_b", empty_b, 1);
    check("rst_full_b", full_b, 0);
    check("rst_pulses", {in_a, out_a, in_b, out_b}, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_clamp", {clamp_a, clamp_b}, 0);

    for (int k = 0; k < 10; k++) run_txn(tbl[k]);

    // Aborted entry on lane 0
    SensA = 2'b01; hold(10);
    check("abort_busy", busy_a[0], 1);
    SensA = 2'b00; hold(10);
    check("abort_idle", busy_a, 0);
    check("abort_cnt_a", cnt_a, 1);
    check("abort_cnt_b", cnt_b, 0);

    // Two-cycle glitch must not reach the FSM
    SensA = 2'b01; hold(2);
    SensA = 2'b00;
    busy_seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      hold(1);
      busy_seen = busy_seen | (|busy_a) | (|busy_b);
    end
    check("glitch_busy", busy_seen, 0);

    // Reset while lane 0 sits in IN2, then finish the pattern
    SensA = 2'b01; hold(10);
    SensB = 2'b01; hold(10);
    check("in2_busy", busy_a[0], 1);
    Reset = 1'b1;
    last_a = '0;
    last_b = '0;
    hold(2);
    Reset = 1'b0;
    hold(1);
    check("post_rst_busy", busy_a, 0);
    check("post_rst_cnt", cnt_a, 0);
    hold(10);
    check("post_rst_ab_idle", busy_a, 0);
    SensA = 2'b00; hold(10);
    SensB = 2'b00; hold(10);
    check("post_rst_final_cnt", cnt_a, 0);
    check("post_rst_final_busy", busy_a, 0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
